// File: rtl/mdio_responder.sv
// MDIO (clause 22) management responder: decodes frames on an oversampled MDC/MDIO pair
// and turns them into single-cycle register read/write strobes on the clk domain.
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter int unsigned PREAMBLE = 32,
    parameter bit          BCAST    = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic [4:0]  m_reg_ra,
    output logic [15:0] m_reg_d,
    output logic        m_reg_wr,
    output logic        m_reg_rd,
    input  logic [15:0] s_reg_d,
    output logic        m_busy
);

    typedef enum logic [3:0] {PRE, ST, OP, PA, RA, TA, WDATA, RDATA, SKIP} state_t;

    localparam logic [5:0] PRE_MIN = 6'(PREAMBLE);

    logic [2:0]  mdc_s;
    logic [1:0]  mdio_s;
    logic        mdc_rise, mdc_fall, mdio_bit;

    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  pa_q, pa_d;
    logic [4:0]  ra_q, ra_d;
    logic [15:0] sh_q, sh_d;
    logic        is_rd_q, is_rd_d;
    logic        addr_ok;

    logic        mdio_o_d, mdio_oe_d, wr_d, rd_d, busy_d;
    logic [4:0]  ra_out_d;
    logic [15:0] d_out_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_s  <= '0;
            mdio_s <= '0;
        end else begin
            mdc_s  <= {mdc_s[1:0], mdc};
            mdio_s <= {mdio_s[0], mdio_i};
        end
    end

    assign mdc_rise = mdc_s[1] & ~mdc_s[2];
    assign mdc_fall = ~mdc_s[1] & mdc_s[2];
    assign mdio_bit = mdio_s[1];

    // Broadcast address is only honoured for writes, so a read can never collide on the bus.
    assign addr_ok = (pa_q == PHY_ADDR) || (BCAST && (pa_q == 5'd0) && !is_rd_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PRE;
            bit_cnt_q <= '0;
            pre_cnt_q <= '0;
            op_q      <= '0;
            pa_q      <= '0;
            ra_q      <= '0;
            sh_q      <= '0;
            is_rd_q   <= 1'b0;
            mdio_o    <= 1'b0;
            mdio_oe   <= 1'b0;
            m_reg_ra  <= '0;
            m_reg_d   <= '0;
            m_reg_wr  <= 1'b0;
            m_reg_rd  <= 1'b0;
            m_busy    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            pre_cnt_q <= pre_cnt_d;
            op_q      <= op_d;
            pa_q      <= pa_d;
            ra_q      <= ra_d;
            sh_q      <= sh_d;
            is_rd_q   <= is_rd_d;
            mdio_o    <= mdio_o_d;
            mdio_oe   <= mdio_oe_d;
            m_reg_ra  <= ra_out_d;
            m_reg_d   <= d_out_d;
            m_reg_wr  <= wr_d;
            m_reg_rd  <= rd_d;
            m_busy    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        pre_cnt_d = pre_cnt_q;
        op_d      = op_q;
        pa_d      = pa_q;
        ra_d      = ra_q;
        sh_d      = sh_q;
        is_rd_d   = is_rd_q;
        mdio_o_d  = mdio_o;
        mdio_oe_d = mdio_oe;
        ra_out_d  = m_reg_ra;
        d_out_d   = m_reg_d;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        busy_d    = m_busy;

        case (state_q)
            PRE: begin
                if (mdc_fall) begin
                    if (mdio_bit) begin
                        if (pre_cnt_q != 6'd32) pre_cnt_d = pre_cnt_q + 6'd1;
                    end else begin
                        pre_cnt_d = '0;
                        if (pre_cnt_q >= PRE_MIN) begin
                            state_d = ST;
                            busy_d  = 1'b1;
                        end
                    end
                end
            end
            ST: begin
                if (mdc_fall) begin
                    bit_cnt_d = '0;
                    if (mdio_bit) begin
                        state_d = OP;
                    end else begin
                        state_d = PRE;
                        busy_d  = 1'b0;
                    end
                end
            end
            OP: begin
                if (mdc_fall) begin
                    op_d = {op_q[0], mdio_bit};
                    if (bit_cnt_q == 5'd0) begin
                        bit_cnt_d = 5'd1;
                    end else begin
                        bit_cnt_d = '0;
                        if ({op_q[0], mdio_bit} == 2'b10) begin
                            is_rd_d = 1'b1;
                            state_d = PA;
                        end else if ({op_q[0], mdio_bit} == 2'b01) begin
                            is_rd_d = 1'b0;
                            state_d = PA;
                        end else begin
                            state_d = PRE;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            PA: begin
                if (mdc_fall) begin
                    pa_d = {pa_q[3:0], mdio_bit};
                    if (bit_cnt_q == 5'd4) begin
                        bit_cnt_d = '0;
                        state_d   = RA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            RA: begin
                if (mdc_fall) begin
                    ra_d = {ra_q[3:0], mdio_bit};
                    if (bit_cnt_q == 5'd4) begin
                        bit_cnt_d = '0;
                        if (addr_ok) begin
                            state_d = TA;
                            if (is_rd_q) begin
                                rd_d     = 1'b1;
                                ra_out_d = {ra_q[3:0], mdio_bit};
                            end
                        end else begin
                            state_d = SKIP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            TA: begin
                // Reads leave TA on the rise after the TA1 sample; writes on the TA2 sample.
                if (mdc_rise && is_rd_q && bit_cnt_q == 5'd1) begin
                    sh_d      = s_reg_d;
                    mdio_oe_d = 1'b1;
                    mdio_o_d  = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = RDATA;
                end else if (mdc_fall) begin
                    if (bit_cnt_q == 5'd0) begin
                        bit_cnt_d = 5'd1;
                    end else if (!is_rd_q) begin
                        bit_cnt_d = '0;
                        state_d   = WDATA;
                    end
                end
            end
            WDATA: begin
                if (mdc_fall) begin
                    sh_d = {sh_q[14:0], mdio_bit};
                    if (bit_cnt_q == 5'd15) begin
                        wr_d      = 1'b1;
                        d_out_d   = {sh_q[14:0], mdio_bit};
                        ra_out_d  = ra_q;
                        bit_cnt_d = '0;
                        state_d   = PRE;
                        busy_d    = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            RDATA: begin
                if (mdc_rise) begin
                    if (bit_cnt_q == 5'd16) begin
                        mdio_oe_d = 1'b0;
                        mdio_o_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = PRE;
                        busy_d    = 1'b0;
                    end else begin
                        mdio_o_d  = sh_q[15];
                        sh_d      = {sh_q[14:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            SKIP: begin
                if (mdc_fall) begin
                    if (bit_cnt_q == 5'd17) begin
                        bit_cnt_d = '0;
                        state_d   = PRE;
                        busy_d    = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = PRE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule
